// File: rtl/relu_layer_stream.sv
// Streaming ReLU layer: N_CH lanes per beat, 2-stage valid/ready pipeline, requantise + saturate.
// Define RELU_LEAKY_EN for leaky ReLU with signed saturation; default build is strict unsigned ReLU.
module relu_layer_stream #(
    parameter int WIDTH      = 8,
    parameter int N_CH       = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 0,
    parameter int FRAME_LEN  = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH*WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*OUT_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic [15:0]               frame_cnt
);

    localparam int QW = WIDTH + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    // Half-LSB rounding constant; collapses to zero when SHIFT is 0
    localparam logic [QW-1:0] RND = (QW'(1) << SHIFT) >> 1;
    localparam bit CFG_OK = (N_CH >= 1) && (N_CH <= 64) &&
                            (OUT_WIDTH >= 2) && (OUT_WIDTH <= WIDTH) &&
                            (SHIFT >= 0) && (SHIFT < WIDTH) &&
                            (FRAME_LEN >= 1) && (LEAK_SHIFT >= 0);

    if (!CFG_OK) begin : g_cfg_err
        $error("relu_layer_stream: unsupported parameter set");
    end

`ifdef RELU_LEAKY_EN
    localparam logic signed [QW-1:0] SMAX =
        {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] SMIN = ~SMAX;
`else
    localparam logic signed [QW-1:0] UMAX =
        {{(QW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
`endif

    function automatic logic signed [QW-1:0] f_act(
        input logic signed [WIDTH-1:0] x
    );
        logic signed [WIDTH-1:0] r;
        logic signed [QW-1:0]    s;
`ifdef RELU_LEAKY_EN
        r = (x < 0) ? (x >>> LEAK_SHIFT) : x;
`else
        r = x[WIDTH-1] ? '0 : x;
`endif
        s = {r[WIDTH-1], r} + $signed(RND);
        return s >>> SHIFT;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] f_sat(
        input logic signed [QW-1:0] q
    );
`ifdef RELU_LEAKY_EN
        if (q > SMAX)
            return SMAX[OUT_WIDTH-1:0];
        else if (q < SMIN)
            return SMIN[OUT_WIDTH-1:0];
        else
            return q[OUT_WIDTH-1:0];
`else
        if (q > UMAX)
            return {OUT_WIDTH{1'b1}};
        else
            return q[OUT_WIDTH-1:0];
`endif
    endfunction

    logic                      r_s1_valid;
    logic                      r_s2_valid;
    logic [N_CH*QW-1:0]        r_s1_q;
    logic [N_CH*OUT_WIDTH-1:0] r_out;
    logic [CW-1:0]             r_cnt;
    logic [15:0]               r_frame;

    logic                      w_s1_adv;
    logic                      w_s2_adv;
    logic                      w_out_xfer;
    logic [N_CH*QW-1:0]        w_s1_q;
    logic [N_CH*OUT_WIDTH-1:0] w_sat;

    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign w_out_xfer = r_s2_valid & out_ready;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_out;
    assign out_last  = r_s2_valid & (r_cnt == LAST);
    assign frame_cnt = r_frame;

    always_comb begin
        w_s1_q = '0;
        for (int k = 0; k < N_CH; k++)
            w_s1_q[k*QW +: QW] = f_act($signed(in_data[k*WIDTH +: WIDTH]));
    end

    always_comb begin
        w_sat = '0;
        for (int k = 0; k < N_CH; k++)
            w_sat[k*OUT_WIDTH +: OUT_WIDTH] = f_sat($signed(r_s1_q[k*QW +: QW]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_q     <= '0;
            r_out      <= '0;
            r_cnt      <= '0;
            r_frame    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid)
                    r_s1_q <= w_s1_q;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_out <= w_sat;
            end
            // Counter follows the beat leaving stage 2
            if (w_out_xfer) begin
                if (r_cnt == LAST) begin
                    r_cnt   <= '0;
                    r_frame <= r_frame + 16'd1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_layer_stream.sv
// Directed bench for relu_layer_stream: three parameter sets, data, backpressure, framing, reset.
// Expected vectors switch on RELU_LEAKY_EN to match the build under test.
module tb_relu_layer_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [63:0] a_in_data, a_out_data;
    logic [15:0] a_frame;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_data, b_out_data;
    logic [15:0] b_frame;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [31:0] c_in_data;
    logic [15:0] c_out_data;
    logic [15:0] c_frame;

    relu_layer_stream #(
        .WIDTH(8), .N_CH(8), .OUT_WIDTH(8), .SHIFT(0),
        .FRAME_LEN(4), .LEAK_SHIFT(3)
    ) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .frame_cnt(a_frame)
    );

    relu_layer_stream #(
        .WIDTH(8), .N_CH(4), .OUT_WIDTH(8), .SHIFT(2),
        .FRAME_LEN(1), .LEAK_SHIFT(3)
    ) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .frame_cnt(b_frame)
    );

    relu_layer_stream #(
        .WIDTH(16), .N_CH(2), .OUT_WIDTH(8), .SHIFT(0),
        .FRAME_LEN(16), .LEAK_SHIFT(3)
    ) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last), .frame_cnt(c_frame)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] RP = 16'b1001_0001_1100_1001;

    // lane7 .. lane0
    localparam logic [63:0] V1 = {8'hF9, 8'h7F, 8'h40, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h80};
    localparam logic [31:0] V2 = {8'hF7, 8'h07, 8'h06, 8'h05};
    localparam logic [31:0] V3 = {16'hFC18, 16'h03E8};
    localparam logic [63:0] V6 = {32'h0, 8'h28, 8'h80, 8'hFF, 8'hC0};
    localparam logic [31:0] E2 = {8'h00, 8'h02, 8'h02, 8'h01};
`ifdef RELU_LEAKY_EN
    localparam logic [63:0] E1 = {8'hFF, 8'h7F, 8'h40, 8'h05, 8'h01, 8'h00, 8'hFF, 8'hF0};
    localparam logic [15:0] E3 = {8'h83, 8'h7F};
    localparam logic [63:0] E6 = {32'h0, 8'h28, 8'hF0, 8'hFF, 8'hF8};
`else
    localparam logic [63:0] E1 = {8'h00, 8'h7F, 8'h40, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00};
    localparam logic [15:0] E3 = {8'h00, 8'hFF};
    localparam logic [63:0] E6 = {32'h0, 8'h28, 8'h00, 8'h00, 8'h00};
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-negative lanes so ReLU passes them through untouched
    function automatic logic [63:0] beat(input int id);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++)
            v[k*8 +: 8] = 8'((id * 8 + k) % 128);
        return v;
    endfunction

    task automatic stream(input int n, input bit bp, input int pos0);
        int          sent, rcvd, occ, pos;
        logic [63:0] pd;
        bit          pstall;
        sent = 0; rcvd = 0; occ = 0; pstall = 0; pd = '0;
        for (int cyc = 0; cyc < 400 && rcvd < n; cyc++) begin
            a_in_valid  = (sent < n);
            a_in_data   = beat(sent);
            a_out_ready = bp ? RP[cyc % 16] : 1'b1;
            @(negedge clk);
            check("in_ready", 64'(a_in_ready), 64'((occ < 2) || a_out_ready));
            if (pstall) begin
                check("hold_valid", 64'(a_out_valid), 64'(1));
                check("hold_data", a_out_data, pd);
            end
            if (a_out_valid)
                check("no_dup", 64'(occ > 0), 64'(1));
            if (a_out_valid && a_out_ready) begin
                pos = pos0 + rcvd;
                check("data", a_out_data, beat(rcvd));
                check("last", 64'(a_out_last), 64'(pos % 4 == 3));
                check("frame", 64'(a_frame), 64'(pos / 4));
                rcvd++;
                occ--;
            end
            if (a_in_valid && a_in_ready) begin
                sent++;
                occ++;
            end
            pstall = a_out_valid && !a_out_ready;
            pd = a_out_data;
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        check("beat_count", 64'(rcvd), 64'(n));
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        tick();
        tick();
        check("rst_valid", 64'(a_out_valid), 64'(0));
        check("rst_data", a_out_data, 64'(0));
        check("rst_last", 64'(a_out_last), 64'(0));
        check("rst_frame", 64'(a_frame), 64'(0));
        check("rst_last_b", 64'(b_out_last), 64'(0));
        rst = 1'b0;
        tick();

        // basic lanes, rounding shift, wide-to-narrow saturation
        a_in_valid = 1; a_in_data = V1;
        b_in_valid = 1; b_in_data = V2;
        c_in_valid = 1; c_in_data = V3;
        tick();
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        check("lat1_valid", 64'(a_out_valid), 64'(0));
        tick();
        check("lat2_valid", 64'(a_out_valid), 64'(1));
        check("relu_lanes", a_out_data, E1);
        check("shift_valid", 64'(b_out_valid), 64'(1));
        check("shift_round", 64'(b_out_data), 64'(E2));
        check("flen1_last", 64'(b_out_last), 64'(1));
        check("sat_valid", 64'(c_out_valid), 64'(1));
        check("sat_lanes", 64'(c_out_data), 64'(E3));
        tick();
        check("drained", 64'(a_out_valid), 64'(0));

        a_in_valid = 1; a_in_data = V6;
        tick();
        a_in_valid = 0;
        tick();
        check("neg_lanes", a_out_data, E6);
        tick();

        rst = 1; tick(); rst = 0;
        stream(20, 1'b1, 0);
        check("bp_frames", 64'(a_frame), 64'(5));

        rst = 1; tick(); rst = 0;
        stream(9, 1'b0, 0);
        check("frame_total", 64'(a_frame), 64'(2));

        // reset with two beats in flight
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = beat(50);
        tick();
        a_in_data = beat(51);
        tick();
        a_in_valid = 0;
        check("full_in_ready", 64'(a_in_ready), 64'(0));
        rst = 1; tick(); rst = 0;
        check("post_rst_valid", 64'(a_out_valid), 64'(0));
        check("post_rst_frame", 64'(a_frame), 64'(0));
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = beat(0);
        tick();
        a_in_valid = 0;
        check("post_rst_lat1", 64'(a_out_valid), 64'(0));
        tick();
        check("post_rst_lat2", 64'(a_out_valid), 64'(1));
        check("post_rst_data", a_out_data, beat(0));
        check("post_rst_last", 64'(a_out_last), 64'(0));
        tick();
        stream(3, 1'b0, 1);
        check("post_rst_frames", 64'(a_frame), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
